cp_pi_bridge: RTL and testbench
===============================

// Module: cp_pi_bridge
// PURPOSE
//  Parametrised successor of the clock-port/Pi SRAM interface. Amiga clock-port (CP) and
//  Raspberry Pi (PI) each get a register window with their own address pointer into a shared
//  single-port SRAM, a round-robin SRAM arbiter, a CP read prefetch buffer, per-side
//  auto-increment control and N_DB doorbell interrupt bits in each direction.
//  Sits between the CP latches (IC2/IC3), the PI GPIO bus and the SRAM.
// PARAMETERS
//  ADDR_W       16  SRAM address width, 9..24; pointer wraps modulo 2**ADDR_W
//  SYNC_STAGES  2   flops on RTC_CS_n/IORD_n/IOWR_n/PI_REQ, 2..3
//  RAM_CYC      2   clocks RAM_OE_n/RAM_WE_n held low per access, >=1
//  N_DB         4   doorbell bits per direction, 1..7
// PORTS
//  CLK       in   1       system clock
//  RST       in   1       asynchronous reset, active high
//  RTC_CS_n  in   1       CP chip select
//  IORD_n    in   1       CP read strobe
//  IOWR_n    in   1       CP write strobe
//  CP_A      in   3       CP register select
//  CP_DIN    in   8       CP write data (from input latch)
//  CP_DOUT   out  8       CP read data (to output latch)
//  CP_LE     out  1       output latch enable (1 = transparent)
//  CP_OE_n   out  1       output latch OE, low during CP read
//  PI_REQ    in   1       PI request, level
//  PI_WR     in   1       PI direction, 1 = write
//  PI_A      in   3       PI register select
//  PI_DIN    in   8       PI write data
//  PI_DOUT   out  8       PI read data, valid while PI_ACK=1
//  PI_ACK    out  1       PI acknowledge
//  RAM_A     out  ADDR_W  SRAM address
//  RAM_DIN   in   8       SRAM read data
//  RAM_DOUT  out  8       SRAM write data
//  RAM_OE_n  out  1       SRAM output enable
//  RAM_WE_n  out  1       SRAM write enable
//  INT6_n    out  1       CP interrupt, low while any CP doorbell pending
//  PI_IRQ    out  1       PI interrupt, high while any PI doorbell pending
// BEHAVIOUR
//  Reset (async, RST=1): ptrs=0, pending=0, AI=1, prefetch buf=0, arbiter IDLE, last-grant=PI;
//   RAM_OE_n=1, RAM_WE_n=1, PI_ACK=0, PI_IRQ=0, INT6_n=1, CP_LE=1, CP_DOUT=0. In-flight
//   accesses are abandoned, no retry after release.
//  Register map (same for both sides, own copy of ptr/ctrl): 0 DATA, 1 DOORBELL, 2 A[7:0],
//   3 A[15:8], 4 A[ADDR_W-1:16] (unused bits read 0), 5 CTRL {bit7 BUSY ro, bit0 AI rw}, 6-7 read 0.
//  CP_OE_n = RTC_CS_n | IORD_n (combinational); CP_LE = CP_OE_n; CP_DOUT selected by CP_A.
//  CP access = synchronised falling edge of (CS&WR) or (CS&RD); event taken once per strobe.
//   Write DATA: RAM[ptr]<=CP_DIN, then ptr+=AI, then prefetch. Write A*: load byte, prefetch.
//   Read DATA: byte returned from prefetch buf; on strobe release ptr+=AI, then prefetch.
//  BUSY=1 from event until prefetch buf updated; max SYNC_STAGES+2*(RAM_CYC+2)+2 clocks.
//  PI access: synchronised PI_REQ rise -> op -> PI_ACK=1 (DATA read: PI_DOUT=RAM byte);
//   PI_ACK holds until synced PI_REQ=0, then 0 next clock. DATA ops post-increment ptr if AI.
//  Arbiter FSM IDLE->RD|WR (RAM_CYC clocks)->DONE->IDLE. One request per side queued.
//   Simultaneous requests: grant side that did NOT win last; single request granted directly.
//   RAM_A/RAM_DOUT stable 1 clock before and during strobe; RD samples RAM_DIN in last strobe clock.
//  Doorbell write v: v[7]=0 -> other side pending |= v[N_DB-1:0]; v[7]=1 -> own pending &= ~v.
//   Read returns own pending. Same-clock set and clear of a bit: set wins.
//  Pointer +1 at 2**ADDR_W-1 wraps to 0; ptr never touches the other side's ptr.
// TESTING
//  CP write A=0x1122 then DATA 0xAA,0xBB,0xCC,0xDD -> RAM[0x1122..0x1125]=AA..DD, CP ptr=0x1126.
//  CP set A=0x1122, read DATA x4 (BUSY polled) -> AA,BB,CC,DD; CTRL.AI=0 -> four reads all AA.
//  PI write A=0x1234, DATA 0x78; PI read back -> PI_DOUT=0x78 with ACK; ACK drops after REQ low.
//  CP DATA write and PI DATA write same clock, twice -> grants alternate PI? no: CP,PI,CP order.
//  CP doorbell 0x05 -> PI_IRQ=1, PI reads 0x05; PI writes 0x85 -> PI_IRQ=0; reverse drives INT6_n.
//  ADDR_W=16 ptr=0xFFFF DATA write -> ptr 0x0000; RST mid-RD -> RAM_OE_n=1 same clock, regs 0.

Source files
------------

// File: rtl/cp_pi_bridge.sv
// Bridge between the Amiga clock-port latches, the Raspberry Pi GPIO bus and one shared SRAM.
// Each side has its own pointer/control window, and a round-robin arbiter owns the RAM strobes.
module cp_pi_bridge #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RAM_CYC     = 2,
    parameter int N_DB        = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RTC_CS_n,
    input  logic              IORD_n,
    input  logic              IOWR_n,
    input  logic [2:0]        CP_A,
    input  logic [7:0]        CP_DIN,
    output logic [7:0]        CP_DOUT,
    output logic              CP_LE,
    output logic              CP_OE_n,
    input  logic              PI_REQ,
    input  logic              PI_WR,
    input  logic [2:0]        PI_A,
    input  logic [7:0]        PI_DIN,
    output logic [7:0]        PI_DOUT,
    output logic              PI_ACK,
    output logic [ADDR_W-1:0] RAM_A,
    input  logic [7:0]        RAM_DIN,
    output logic [7:0]        RAM_DOUT,
    output logic              RAM_OE_n,
    output logic              RAM_WE_n,
    output logic              INT6_n,
    output logic              PI_IRQ
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_RD, ARB_WR, ARB_DONE} arb_state_t;

    function automatic logic [7:0] get_byte(input logic [ADDR_W-1:0] p, input int idx);
        logic [23:0] e;
        e = 24'(p);
        return e[idx*8 +: 8];
    endfunction

    function automatic logic [ADDR_W-1:0] set_byte(input logic [ADDR_W-1:0] p, input int idx,
                                                   input logic [7:0] v);
        logic [23:0] e;
        e = 24'(p);
        e[idx*8 +: 8] = v;
        return e[ADDR_W-1:0];
    endfunction

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, req_sync;
    logic cp_wr_on, cp_rd_on, pi_req_s, cp_wr_d, cp_rd_d, pi_req_d;
    logic cp_wr_ev, cp_rd_ev, cp_rd_end, pi_ev;

    arb_state_t arb_state, arb_next;
    logic [7:0] cyc, rd_data, dout_q, sel_wdata;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic grant_cp_q, last_cp, pick_cp, sel_wr, any_req, take_cp, take_pi, last_cyc;
    logic done_cp, done_pi;

    logic [ADDR_W-1:0] cp_ptr, pi_ptr, cp_inc, pi_inc;
    logic [7:0] cp_buf, cp_wdata, pi_wdata, pi_dout, cp_rd_val, pi_rd_val;
    logic [2:0] cp_rd_reg;
    logic cp_ai, cp_busy, cp_req, cp_req_wr, cp_wait_wr, cp_wait_pf;
    logic pi_ai, pi_req, pi_req_wr, pi_wait, pi_ack;

    logic [N_DB-1:0] cp_pend, pi_pend, cp_set, cp_clr, pi_set, pi_clr;
    logic cp_db_wr, pi_db_wr;

    // Strobes arrive asynchronously; events are edges of the synchronised levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_sync  <= '1;
            rd_sync  <= '1;
            wr_sync  <= '1;
            req_sync <= '0;
            cp_wr_d  <= 1'b0;
            cp_rd_d  <= 1'b0;
            pi_req_d <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], RTC_CS_n};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], IORD_n};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], IOWR_n};
            req_sync <= {req_sync[SYNC_STAGES-2:0], PI_REQ};
            cp_wr_d  <= cp_wr_on;
            cp_rd_d  <= cp_rd_on;
            pi_req_d <= pi_req_s;
        end
    end

    assign cp_wr_on  = ~cs_sync[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES-1];
    assign cp_rd_on  = ~cs_sync[SYNC_STAGES-1] & ~rd_sync[SYNC_STAGES-1];
    assign pi_req_s  = req_sync[SYNC_STAGES-1];
    assign cp_wr_ev  = cp_wr_on & ~cp_wr_d;
    assign cp_rd_ev  = cp_rd_on & ~cp_rd_d;
    assign cp_rd_end = ~cp_rd_on & cp_rd_d;
    assign pi_ev     = pi_req_s & ~pi_req_d;

    // On a tie the side that did not win last time gets the RAM.
    assign any_req   = cp_req | pi_req;
    assign pick_cp   = cp_req & (~pi_req | ~last_cp);
    assign sel_wr    = pick_cp ? cp_req_wr : pi_req_wr;
    assign sel_addr  = pick_cp ? cp_ptr : pi_ptr;
    assign sel_wdata = pick_cp ? cp_wdata : pi_wdata;
    assign take_cp   = (arb_state == ARB_IDLE) & any_req & pick_cp;
    assign take_pi   = (arb_state == ARB_IDLE) & any_req & ~pick_cp;
    assign last_cyc  = (cyc == 8'(RAM_CYC - 1));
    assign done_cp   = (arb_state == ARB_DONE) & grant_cp_q;
    assign done_pi   = (arb_state == ARB_DONE) & ~grant_cp_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) arb_state <= ARB_IDLE;
        else     arb_state <= arb_next;
    end

    always_comb begin
        arb_next = arb_state;
        case (arb_state)
            ARB_IDLE: if (any_req) arb_next = sel_wr ? ARB_WR : ARB_RD;
            ARB_RD,
            ARB_WR:   if (last_cyc) arb_next = ARB_DONE;
            default:  arb_next = ARB_IDLE;
        endcase
    end

    // While idle the winner's address/data are already driven, giving one clock of setup.
    always_comb begin
        RAM_OE_n = (arb_state != ARB_RD);
        RAM_WE_n = (arb_state != ARB_WR);
        RAM_A    = (arb_state == ARB_IDLE) ? sel_addr  : addr_q;
        RAM_DOUT = (arb_state == ARB_IDLE) ? sel_wdata : dout_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cp_q <= 1'b0;
            last_cp    <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            cyc        <= '0;
            rd_data    <= '0;
        end else begin
            if (take_cp || take_pi) begin
                grant_cp_q <= pick_cp;
                last_cp    <= pick_cp;
                addr_q     <= sel_addr;
                dout_q     <= sel_wdata;
                cyc        <= '0;
            end else if (arb_state == ARB_RD || arb_state == ARB_WR) begin
                cyc <= cyc + 8'd1;
            end
            if (arb_state == ARB_RD && last_cyc) rd_data <= RAM_DIN;
        end
    end

    assign cp_db_wr = cp_wr_ev & (CP_A == 3'd1);
    assign pi_db_wr = pi_ev & PI_WR & (PI_A == 3'd1);

    always_comb begin
        cp_set = '0;
        cp_clr = '0;
        pi_set = '0;
        pi_clr = '0;
        if (cp_db_wr && !CP_DIN[7]) pi_set = CP_DIN[N_DB-1:0];
        if (cp_db_wr &&  CP_DIN[7]) cp_clr = CP_DIN[N_DB-1:0];
        if (pi_db_wr && !PI_DIN[7]) cp_set = PI_DIN[N_DB-1:0];
        if (pi_db_wr &&  PI_DIN[7]) pi_clr = PI_DIN[N_DB-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cp_pend <= '0;
            pi_pend <= '0;
        end else begin
            cp_pend <= (cp_pend & ~cp_clr) | cp_set;
            pi_pend <= (pi_pend & ~pi_clr) | pi_set;
        end
    end

    assign INT6_n = ~|cp_pend;
    assign PI_IRQ = |pi_pend;

    always_comb begin
        cp_rd_val = 8'h00;
        pi_rd_val = 8'h00;
        case (CP_A)
            3'd0: cp_rd_val = cp_buf;
            3'd1: cp_rd_val = {{(8-N_DB){1'b0}}, cp_pend};
            3'd2: cp_rd_val = get_byte(cp_ptr, 0);
            3'd3: cp_rd_val = get_byte(cp_ptr, 1);
            3'd4: cp_rd_val = get_byte(cp_ptr, 2);
            3'd5: cp_rd_val = {cp_busy, 6'b0, cp_ai};
            default: cp_rd_val = 8'h00;
        endcase
        case (PI_A)
            3'd1: pi_rd_val = {{(8-N_DB){1'b0}}, pi_pend};
            3'd2: pi_rd_val = get_byte(pi_ptr, 0);
            3'd3: pi_rd_val = get_byte(pi_ptr, 1);
            3'd4: pi_rd_val = get_byte(pi_ptr, 2);
            3'd5: pi_rd_val = {pi_wait, 6'b0, pi_ai};
            default: pi_rd_val = 8'h00;
        endcase
    end

    assign CP_OE_n = RTC_CS_n | IORD_n;
    assign CP_LE   = CP_OE_n;
    assign CP_DOUT = cp_rd_val;
    assign cp_inc  = {{(ADDR_W-1){1'b0}}, cp_ai};
    assign pi_inc  = {{(ADDR_W-1){1'b0}}, pi_ai};

    // CP side: DATA reads are served from the prefetch buffer, which is refilled after every pointer move.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cp_ptr     <= '0;
            cp_ai      <= 1'b1;
            cp_buf     <= '0;
            cp_busy    <= 1'b0;
            cp_req     <= 1'b0;
            cp_req_wr  <= 1'b0;
            cp_wdata   <= '0;
            cp_wait_wr <= 1'b0;
            cp_wait_pf <= 1'b0;
            cp_rd_reg  <= '0;
        end else begin
            if (take_cp) cp_req <= 1'b0;
            if (done_cp && cp_wait_wr) begin
                cp_wait_wr <= 1'b0;
                cp_ptr     <= cp_ptr + cp_inc;
                cp_req     <= 1'b1;
                cp_req_wr  <= 1'b0;
                cp_wait_pf <= 1'b1;
            end else if (done_cp && cp_wait_pf) begin
                cp_buf <= rd_data;
                if (!cp_req) begin
                    cp_wait_pf <= 1'b0;
                    cp_busy    <= 1'b0;
                end
            end
            if (cp_wr_ev) begin
                case (CP_A)
                    3'd0: begin
                        cp_req     <= 1'b1;
                        cp_req_wr  <= 1'b1;
                        cp_wdata   <= CP_DIN;
                        cp_wait_wr <= 1'b1;
                        cp_wait_pf <= 1'b0;
                        cp_busy    <= 1'b1;
                    end
                    3'd2, 3'd3, 3'd4: begin
                        cp_ptr     <= set_byte(cp_ptr, int'(CP_A) - 2, CP_DIN);
                        cp_req     <= 1'b1;
                        cp_req_wr  <= 1'b0;
                        cp_wait_pf <= 1'b1;
                        cp_busy    <= 1'b1;
                    end
                    3'd5: cp_ai <= CP_DIN[0];
                    default: ;
                endcase
            end
            if (cp_rd_ev) cp_rd_reg <= CP_A;
            if (cp_rd_end && cp_rd_reg == 3'd0) begin
                cp_ptr     <= cp_ptr + cp_inc;
                cp_req     <= 1'b1;
                cp_req_wr  <= 1'b0;
                cp_wait_pf <= 1'b1;
                cp_busy    <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pi_ptr    <= '0;
            pi_ai     <= 1'b1;
            pi_req    <= 1'b0;
            pi_req_wr <= 1'b0;
            pi_wdata  <= '0;
            pi_wait   <= 1'b0;
            pi_ack    <= 1'b0;
            pi_dout   <= '0;
        end else begin
            if (take_pi) pi_req <= 1'b0;
            if (pi_ack && !pi_req_s) pi_ack <= 1'b0;
            if (done_pi && pi_wait) begin
                pi_wait <= 1'b0;
                pi_ack  <= 1'b1;
                pi_ptr  <= pi_ptr + pi_inc;
                if (!pi_req_wr) pi_dout <= rd_data;
            end
            if (pi_ev) begin
                if (PI_A == 3'd0) begin
                    pi_req    <= 1'b1;
                    pi_req_wr <= PI_WR;
                    pi_wdata  <= PI_DIN;
                    pi_wait   <= 1'b1;
                end else begin
                    pi_ack  <= 1'b1;
                    pi_dout <= pi_rd_val;
                    if (PI_WR) begin
                        case (PI_A)
                            3'd2, 3'd3, 3'd4: pi_ptr <= set_byte(pi_ptr, int'(PI_A) - 2, PI_DIN);
                            3'd5: pi_ai <= PI_DIN[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign PI_ACK  = pi_ack;
    assign PI_DOUT = pi_dout;

endmodule

// File: tb/tb_cp_pi_bridge.sv
// Directed bench for cp_pi_bridge with a behavioural async SRAM and a RAM strobe recorder.
module tb_cp_pi_bridge;

    logic        CLK, RST;
    logic        RTC_CS_n, IORD_n, IOWR_n;
    logic [2:0]  CP_A;
    logic [7:0]  CP_DIN, CP_DOUT;
    logic        CP_LE, CP_OE_n;
    logic        PI_REQ, PI_WR;
    logic [2:0]  PI_A;
    logic [7:0]  PI_DIN, PI_DOUT;
    logic        PI_ACK;
    logic [15:0] RAM_A;
    logic [7:0]  RAM_DIN, RAM_DOUT;
    logic        RAM_OE_n, RAM_WE_n, INT6_n, PI_IRQ;

    logic [7:0]  mem [0:65535];
    logic        mem_ready = 1'b0;
    logic        strobe_prev = 1'b0;
    logic [16:0] grants [$];
    logic [16:0] exp_grants [6];
    logic [7:0]  q, q1, q2;
    int          n_checks = 0;
    int          n_fails = 0;

    cp_pi_bridge #(.ADDR_W(16), .SYNC_STAGES(2), .RAM_CYC(2), .N_DB(4)) dut (
        .CLK(CLK), .RST(RST), .RTC_CS_n(RTC_CS_n), .IORD_n(IORD_n), .IOWR_n(IOWR_n),
        .CP_A(CP_A), .CP_DIN(CP_DIN), .CP_DOUT(CP_DOUT), .CP_LE(CP_LE), .CP_OE_n(CP_OE_n),
        .PI_REQ(PI_REQ), .PI_WR(PI_WR), .PI_A(PI_A), .PI_DIN(PI_DIN), .PI_DOUT(PI_DOUT),
        .PI_ACK(PI_ACK), .RAM_A(RAM_A), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT),
        .RAM_OE_n(RAM_OE_n), .RAM_WE_n(RAM_WE_n), .INT6_n(INT6_n), .PI_IRQ(PI_IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign RAM_DIN = mem[RAM_A];

    // SRAM model plus a log of every strobe start as {is_write, address}.
    always @(negedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            if ((!RAM_OE_n || !RAM_WE_n) && !strobe_prev) grants.push_back({!RAM_WE_n, RAM_A});
            strobe_prev <= !RAM_OE_n || !RAM_WE_n;
            if (!RAM_WE_n) mem[RAM_A] <= RAM_DOUT;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 400000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock-port strobe; q is what the output latch would see at the end of it.
    task automatic applyStimulus(input logic wr, input logic [2:0] a, input logic [7:0] d,
                                 output logic [7:0] qo);
        @(negedge CLK);
        CP_A = a;
        CP_DIN = d;
        RTC_CS_n = 1'b0;
        if (wr) IOWR_n = 1'b0;
        else    IORD_n = 1'b0;
        repeat (5) @(negedge CLK);
        qo = CP_DOUT;
        RTC_CS_n = 1'b1;
        IOWR_n = 1'b1;
        IORD_n = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic waitIdle(input string tag);
        logic [7:0] c;
        c = 8'h80;
        for (int i = 0; i < 10 && c[7]; i++) applyStimulus(1'b0, 3'd5, 8'h00, c);
        checkOutput(tag, {31'b0, c[7]}, 32'h0);
    endtask

    task automatic cpWrite(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        applyStimulus(1'b1, a, d, dummy);
        waitIdle("cp_wr_busy");
    endtask

    task automatic cpRead(input logic [2:0] a, output logic [7:0] qo);
        applyStimulus(1'b0, a, 8'h00, qo);
        waitIdle("cp_rd_busy");
    endtask

    task automatic piAccess(input logic wr, input logic [2:0] a, input logic [7:0] d,
                            output logic [7:0] qo);
        int n;
        @(negedge CLK);
        PI_A = a;
        PI_WR = wr;
        PI_DIN = d;
        PI_REQ = 1'b1;
        n = 0;
        while (!PI_ACK && n < 60) begin @(negedge CLK); n++; end
        checkOutput("pi_ack_rise", {31'b0, PI_ACK}, 32'h1);
        qo = PI_DOUT;
        PI_REQ = 1'b0;
        n = 0;
        while (PI_ACK && n < 20) begin @(negedge CLK); n++; end
        checkOutput("pi_ack_fall", {31'b0, PI_ACK}, 32'h0);
    endtask

    initial begin
        int n;
        RST = 1'b1;
        RTC_CS_n = 1'b1; IORD_n = 1'b1; IOWR_n = 1'b1;
        CP_A = 3'd0; CP_DIN = 8'h00;
        PI_REQ = 1'b0; PI_WR = 1'b0; PI_A = 3'd0; PI_DIN = 8'h00;
        repeat (3) @(negedge CLK);
        checkOutput("rst_oe",    {31'b0, RAM_OE_n}, 32'h1);
        checkOutput("rst_we",    {31'b0, RAM_WE_n}, 32'h1);
        checkOutput("rst_ack",   {31'b0, PI_ACK},   32'h0);
        checkOutput("rst_irq",   {31'b0, PI_IRQ},   32'h0);
        checkOutput("rst_int6",  {31'b0, INT6_n},   32'h1);
        checkOutput("rst_le",    {31'b0, CP_LE},    32'h1);
        checkOutput("rst_cpdout", {24'b0, CP_DOUT}, 32'h00);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        cpRead(3'd5, q);  checkOutput("ctrl_reset", {24'b0, q}, 32'h01);
        @(negedge CLK);
        CP_A = 3'd5; RTC_CS_n = 1'b0; IORD_n = 1'b0;
        #1;
        checkOutput("cp_oe_low", {31'b0, CP_OE_n}, 32'h0);
        checkOutput("cp_le_low", {31'b0, CP_LE},   32'h0);
        @(negedge CLK);
        RTC_CS_n = 1'b1; IORD_n = 1'b1;
        repeat (4) @(negedge CLK);

        $display("[TB] CP burst write");
        cpWrite(3'd2, 8'h22);
        cpWrite(3'd3, 8'h11);
        cpWrite(3'd0, 8'hAA);
        cpWrite(3'd0, 8'hBB);
        cpWrite(3'd0, 8'hCC);
        cpWrite(3'd0, 8'hDD);
        checkOutput("ram_1122", {24'b0, mem[16'h1122]}, 32'hAA);
        checkOutput("ram_1123", {24'b0, mem[16'h1123]}, 32'hBB);
        checkOutput("ram_1124", {24'b0, mem[16'h1124]}, 32'hCC);
        checkOutput("ram_1125", {24'b0, mem[16'h1125]}, 32'hDD);
        cpRead(3'd2, q);  checkOutput("cp_ptr_lo", {24'b0, q}, 32'h26);
        cpRead(3'd3, q);  checkOutput("cp_ptr_hi", {24'b0, q}, 32'h11);

        $display("[TB] CP prefetched reads");
        cpWrite(3'd2, 8'h22);
        cpRead(3'd0, q);  checkOutput("cp_rd0", {24'b0, q}, 32'hAA);
        cpRead(3'd0, q);  checkOutput("cp_rd1", {24'b0, q}, 32'hBB);
        cpRead(3'd0, q);  checkOutput("cp_rd2", {24'b0, q}, 32'hCC);
        cpRead(3'd0, q);  checkOutput("cp_rd3", {24'b0, q}, 32'hDD);
        cpWrite(3'd5, 8'h00);
        cpRead(3'd5, q);  checkOutput("ctrl_ai0", {24'b0, q}, 32'h00);
        cpWrite(3'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            cpRead(3'd0, q);
            checkOutput("cp_rd_noinc", {24'b0, q}, 32'hAA);
        end
        cpWrite(3'd5, 8'h01);

        $display("[TB] PI access");
        piAccess(1'b1, 3'd2, 8'h34, q);
        piAccess(1'b1, 3'd3, 8'h12, q);
        piAccess(1'b1, 3'd0, 8'h78, q);
        checkOutput("ram_1234", {24'b0, mem[16'h1234]}, 32'h78);
        piAccess(1'b1, 3'd2, 8'h34, q);
        @(negedge CLK);
        PI_A = 3'd0; PI_WR = 1'b0; PI_REQ = 1'b1;
        n = 0;
        while (!PI_ACK && n < 60) begin @(negedge CLK); n++; end
        checkOutput("pi_rd_ack",  {31'b0, PI_ACK}, 32'h1);
        checkOutput("pi_rd_data", {24'b0, PI_DOUT}, 32'h78);
        repeat (3) @(negedge CLK);
        checkOutput("pi_ack_hold", {31'b0, PI_ACK}, 32'h1);
        PI_REQ = 1'b0;
        @(negedge CLK);
        checkOutput("pi_ack_sync", {31'b0, PI_ACK}, 32'h1);
        n = 0;
        while (PI_ACK && n < 10) begin @(negedge CLK); n++; end
        checkOutput("pi_ack_drop", {31'b0, PI_ACK}, 32'h0);
        piAccess(1'b0, 3'd2, 8'h00, q);  checkOutput("pi_ptr_lo", {24'b0, q}, 32'h35);

        $display("[TB] arbitration");
        cpWrite(3'd2, 8'h00);
        cpWrite(3'd3, 8'h20);
        piAccess(1'b1, 3'd2, 8'hFF, q);
        piAccess(1'b1, 3'd3, 8'h2F, q);
        piAccess(1'b1, 3'd0, 8'h00, q);
        grants.delete();
        fork
            applyStimulus(1'b1, 3'd0, 8'h11, q1);
            piAccess(1'b1, 3'd0, 8'h22, q2);
        join
        waitIdle("arb1_busy");
        fork
            applyStimulus(1'b1, 3'd0, 8'h33, q1);
            piAccess(1'b1, 3'd0, 8'h44, q2);
        join
        waitIdle("arb2_busy");
        exp_grants = '{17'h12000, 17'h13000, 17'h02001, 17'h13001, 17'h12001, 17'h02002};
        checkOutput("grant_count", grants.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            checkOutput("grant_order", (i < grants.size()) ? {15'b0, grants[i]} : 32'hFFFF_FFFF,
                        {15'b0, exp_grants[i]});
        checkOutput("ram_2000", {24'b0, mem[16'h2000]}, 32'h11);
        checkOutput("ram_3000", {24'b0, mem[16'h3000]}, 32'h22);
        checkOutput("ram_2001", {24'b0, mem[16'h2001]}, 32'h33);
        checkOutput("ram_3001", {24'b0, mem[16'h3001]}, 32'h44);

        $display("[TB] doorbells");
        cpWrite(3'd1, 8'h05);
        checkOutput("db_pi_irq", {31'b0, PI_IRQ}, 32'h1);
        checkOutput("db_int6_q", {31'b0, INT6_n}, 32'h1);
        piAccess(1'b0, 3'd1, 8'h00, q);  checkOutput("db_pi_rd", {24'b0, q}, 32'h05);
        piAccess(1'b1, 3'd1, 8'h85, q);
        checkOutput("db_pi_clr", {31'b0, PI_IRQ}, 32'h0);
        piAccess(1'b1, 3'd1, 8'h03, q);
        checkOutput("db_int6", {31'b0, INT6_n}, 32'h0);
        cpRead(3'd1, q);  checkOutput("db_cp_rd", {24'b0, q}, 32'h03);
        cpWrite(3'd1, 8'h83);
        checkOutput("db_int6_clr", {31'b0, INT6_n}, 32'h1);
        checkOutput("db_irq_quiet", {31'b0, PI_IRQ}, 32'h0);

        $display("[TB] pointer wrap");
        cpWrite(3'd2, 8'hFF);
        cpWrite(3'd3, 8'hFF);
        cpWrite(3'd0, 8'h5A);
        checkOutput("ram_ffff", {24'b0, mem[16'hFFFF]}, 32'h5A);
        cpRead(3'd2, q);  checkOutput("wrap_lo", {24'b0, q}, 32'h00);
        cpRead(3'd3, q);  checkOutput("wrap_hi", {24'b0, q}, 32'h00);
        piAccess(1'b0, 3'd3, 8'h00, q);  checkOutput("pi_ptr_kept_hi", {24'b0, q}, 32'h30);
        piAccess(1'b0, 3'd2, 8'h00, q);  checkOutput("pi_ptr_kept_lo", {24'b0, q}, 32'h02);

        $display("[TB] reset during read");
        cpWrite(3'd3, 8'h55);
        cpWrite(3'd5, 8'h00);
        @(negedge CLK);
        PI_A = 3'd0; PI_WR = 1'b0; PI_REQ = 1'b1;
        n = 0;
        while (RAM_OE_n && n < 30) begin @(negedge CLK); n++; end
        checkOutput("rd_started", {31'b0, RAM_OE_n}, 32'h0);
        RST = 1'b1;
        #1;
        checkOutput("rst_mid_oe",  {31'b0, RAM_OE_n}, 32'h1);
        checkOutput("rst_mid_ack", {31'b0, PI_ACK},   32'h0);
        PI_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        grants.delete();
        repeat (10) @(negedge CLK);
        checkOutput("no_retry", grants.size(), 32'd0);
        checkOutput("no_ack",   {31'b0, PI_ACK}, 32'h0);
        cpRead(3'd3, q);  checkOutput("rst_cp_ptr", {24'b0, q}, 32'h00);
        cpRead(3'd5, q);  checkOutput("rst_cp_ai",  {24'b0, q}, 32'h01);
        piAccess(1'b0, 3'd3, 8'h00, q);  checkOutput("rst_pi_ptr", {24'b0, q}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
